// File: rtl/rem_pkg.sv
// Shared types and widths for the remainder scheduler: FSM state encoding,
// sign-magnitude operand width and remainder result width.
package rem_pkg;

   localparam int OP_W  = 3;
   localparam int MAG_W = OP_W - 1;
   localparam int RES_W = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage : rem_pkg

// File: rtl/rem_sched_rem.sv
// Combinational sign-magnitude remainder unit. The remainder takes the
// numerator sign; a zero-magnitude denominator flags divbyzero and passes the numerator through.
module rem_sched_rem
   import rem_pkg::*;
(
   input  logic [OP_W-1:0]  num,
   input  logic [OP_W-1:0]  den,
   output logic [RES_W-1:0] remainder,
   output logic             divbyzero
);

   logic [MAG_W-1:0] mag;

   // Magnitudes are at most 3, so three conditional subtractions always
   // reach the remainder, even for a divisor of 1.
   always_comb begin
      divbyzero = (den[MAG_W-1:0] == '0);
      mag       = num[MAG_W-1:0];
      for (int i = 0; i < 3; i++) begin
         if (!divbyzero && (mag >= den[MAG_W-1:0])) begin
            mag = mag - den[MAG_W-1:0];
         end
      end
      remainder              = '0;
      remainder[RES_W-1]     = num[OP_W-1];
      remainder[MAG_W-1:0]   = mag;
   end

endmodule : rem_sched_rem

// File: rtl/rem_sched.sv
// Two-requester round-robin scheduler in front of one shared remainder unit;
// each operation takes IDLE -> CALC -> RESP with a one-cycle ack in RESP.
module rem_sched
   import rem_pkg::*;
#(
   parameter int DZ_CNT_W = 4
)
(
   input  logic                clk,
   input  logic                rst,
   input  logic                req0,
   input  logic                req1,
   input  logic [OP_W-1:0]     num0,
   input  logic [OP_W-1:0]     num1,
   input  logic [OP_W-1:0]     den0,
   input  logic [OP_W-1:0]     den1,
   output logic                ack0,
   output logic                ack1,
   output logic [RES_W-1:0]    rdata,
   output logic                rdz,
   output logic                rid,
   output logic                busy,
   output logic [DZ_CNT_W-1:0] dz_count
);

   state_t           state;
   state_t           state_nxt;
   logic             last_gnt;
   logic             gnt_valid;
   logic             gnt_id;
   logic [OP_W-1:0]  num_q;
   logic [OP_W-1:0]  den_q;
   logic [RES_W-1:0] rem_out;
   logic             rem_dz;

   // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      gnt_valid = req0 | req1;
      gnt_id    = 1'b0;
      if (req0 && req1) begin
         gnt_id = ~last_gnt;
      end else if (req1) begin
         gnt_id = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (gnt_valid) state_nxt = CALC;
         CALC:    state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // last_gnt resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt <= 1'b1;
         num_q    <= '0;
         den_q    <= '0;
         rid      <= 1'b0;
         rdata    <= '0;
         rdz      <= 1'b0;
         ack0     <= 1'b0;
         ack1     <= 1'b0;
         dz_count <= '0;
      end else begin
         ack0 <= 1'b0;
         ack1 <= 1'b0;
         unique case (state)
            IDLE: begin
               if (gnt_valid) begin
                  num_q    <= gnt_id ? num1 : num0;
                  den_q    <= gnt_id ? den1 : den0;
                  rid      <= gnt_id;
                  last_gnt <= gnt_id;
               end
            end
            CALC: begin
               rdata <= rem_out;
               rdz   <= rem_dz;
               ack0  <= ~rid;
               ack1  <= rid;
               if (rem_dz && (dz_count != '1)) begin
                  dz_count <= dz_count + DZ_CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (state != IDLE);

   rem_sched_rem u_rem (
      .num       (num_q),
      .den       (den_q),
      .remainder (rem_out),
      .divbyzero (rem_dz)
   );

endmodule : rem_sched

// File: tb/tb_rem_sched.sv
// Directed scoreboard bench for rem_sched: expected results are queued at
// request time and popped when an ack appears.
module tb_rem_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic       req0, req1;
   logic [2:0] num0, num1, den0, den1;
   logic       ack0, ack1;
   logic [4:0] rdata;
   logic       rdz, rid, busy;
   logic [3:0] dz_count;

   typedef struct packed {
      logic       id;
      logic [4:0] data;
      logic       dz;
   } exp_t;

   exp_t sb[$];
   int   total  = 0;
   int   bad    = 0;
   int   exp_dz = 0;

   rem_sched #(.DZ_CNT_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .req0     (req0),
      .req1     (req1),
      .num0     (num0),
      .num1     (num1),
      .den0     (den0),
      .den1     (den1),
      .ack0     (ack0),
      .ack1     (ack1),
      .rdata    (rdata),
      .rdz      (rdz),
      .rid      (rid),
      .busy     (busy),
      .dz_count (dz_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic exp_t mk_exp(input logic id, input logic [2:0] n, input logic [2:0] d);
      exp_t       e;
      logic [1:0] dm;
      dm     = d[1:0];
      e.id   = id;
      e.dz   = (dm == 2'b00);
      e.data = {n[2], 2'b00, (e.dz ? n[1:0] : 2'(n[1:0] % dm))};
      return e;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst    = 1'b0;
      exp_dz = 0;
      sb.delete();
   endtask

   // Wait (bounded) for an ack, then check latency and the popped expectation.
   task automatic wait_ack(input string tag, input int exp_lat);
      int   n    = 0;
      bit   seen = 1'b0;
      exp_t e;
      while (!seen && n < 20) begin
         tick();
         n++;
         if (ack0 || ack1) seen = 1'b1;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      if (sb.size() == 0) begin
         check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
         e = sb.pop_front();
         if (seen) begin
            if (e.dz) exp_dz = (exp_dz == 15) ? 15 : exp_dz + 1;
            check({tag, "_lat"},   32'(n),        32'(exp_lat));
            check({tag, "_both"},  32'(ack0 & ack1), 32'd0);
            check({tag, "_ack1"},  32'(ack1),     32'(e.id));
            check({tag, "_rid"},   32'(rid),      32'(e.id));
            check({tag, "_rdata"}, 32'(rdata),    32'(e.data));
            check({tag, "_rdz"},   32'(rdz),      32'(e.dz));
            check({tag, "_dzcnt"}, 32'(dz_count), 32'(exp_dz));
            check({tag, "_busy"},  32'(busy),     32'd1);
         end
      end
   endtask

   // Single request from the given requester; operands are scrambled while busy.
   task automatic issue(input string tag, input logic id, input logic [2:0] n, input logic [2:0] d);
      sb.push_back(mk_exp(id, n, d));
      if (id) begin
         req1 = 1'b1; num1 = n; den1 = d;
      end else begin
         req0 = 1'b1; num0 = n; den0 = d;
      end
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      num0 = 3'($urandom);
      num1 = 3'($urandom);
      den0 = 3'($urandom);
      den1 = 3'($urandom);
      wait_ack(tag, 1);
      tick();
      check({tag, "_idle_ack"},  32'({ack1, ack0}), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy),         32'd0);
   endtask

   initial begin
      rst  = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      num0 = '0;   num1 = '0;
      den0 = '0;   den1 = '0;

      // Reset state and idle behaviour
      do_reset();
      check("rst_busy",  32'(busy),     32'd0);
      check("rst_acks",  32'({ack1, ack0}), 32'd0);
      check("rst_rdata", 32'(rdata),    32'd0);
      check("rst_rdz",   32'(rdz),      32'd0);
      check("rst_rid",   32'(rid),      32'd0);
      check("rst_dzcnt", 32'(dz_count), 32'd0);
      tick();
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_acks", 32'({ack1, ack0}), 32'd0);

      // Single requester and divide-by-zero
      issue("single0", 1'b0, 3'b011, 3'b010);
      issue("dz1",     1'b1, 3'b110, 3'b100);

      // Contention from reset: strict alternation starting at requester 0
      do_reset();
      num0 = 3'b011; den0 = 3'b010;
      num1 = 3'b111; den1 = 3'b011;
      for (int i = 0; i < 4; i++) begin
         sb.push_back(i[0] ? mk_exp(1'b1, 3'b111, 3'b011) : mk_exp(1'b0, 3'b011, 3'b010));
      end
      req0 = 1'b1;
      req1 = 1'b1;
      wait_ack("rr0", 2);
      wait_ack("rr1", 3);
      wait_ack("rr2", 3);
      wait_ack("rr3", 3);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();
      check("rr_end_acks", 32'({ack1, ack0}), 32'd0);

      // Reset in CALC aborts the operation and restores requester-0 priority
      issue("pre_abort", 1'b0, 3'b001, 3'b011);
      num0 = 3'b010; den0 = 3'b011;
      num1 = 3'b001; den1 = 3'b000;
      req0 = 1'b1;
      req1 = 1'b1;
      tick();
      req0 = 1'b0;
      req1 = 1'b0;
      check("abort_in_calc", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst    = 1'b0;
      exp_dz = 0;
      check("abort_busy",  32'(busy),     32'd0);
      check("abort_acks",  32'({ack1, ack0}), 32'd0);
      check("abort_rdata", 32'(rdata),    32'd0);
      check("abort_rdz",   32'(rdz),      32'd0);
      check("abort_rid",   32'(rid),      32'd0);
      check("abort_dzcnt", 32'(dz_count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("abort_no_ack", 32'({ack1, ack0}), 32'd0);
      end
      sb.push_back(mk_exp(1'b0, 3'b010, 3'b011));
      req0 = 1'b1;
      req1 = 1'b1;
      wait_ack("abort_prio", 2);
      req0 = 1'b0;
      req1 = 1'b0;
      tick();

      // Saturation of the divide-by-zero counter
      for (int i = 0; i < 20; i++) begin
         issue("sat", i[0], 3'(i), (i[0] ? 3'b100 : 3'b000));
      end
      check("sat_final", 32'(dz_count), 32'hF);
      issue("sat_hold", 1'b0, 3'b101, 3'b000);
      check("sat_hold_val", 32'(dz_count), 32'hF);

      // Exhaustive operand sweep through both requesters
      for (int id = 0; id < 2; id++) begin
         for (int n = 0; n < 8; n++) begin
            for (int d = 0; d < 8; d++) begin
               issue("sweep", id[0], 3'(n), 3'(d));
            end
         end
      end

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_rem_sched
